key_debounce_multi: RTL and testbench

Parametrised N-channel push-button conditioner; successor to the single-key debouncer.
- Per key: 2-flop synchroniser, configurable-length stability filter, polarity normalisation.
- Outputs per key: debounced level plus one-cycle press and release event pulses, with an optional long-press event.
- Sits between board button pins and control FSMs/menu logic in the 125 MHz fabric domain.

---
 rtl/key_pkg.sv | 17 +
 rtl/key_debounce_ch.sv | 131 +++++++++++++
 rtl/key_debounce_multi.sv | 51 +++++
 tb/tb_key_debounce_multi.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared constants and helpers for the push-button conditioning blocks.
//   KEY_DEB_40MS_125M : 40 ms debounce window at 125 MHz, in clock cycles
//   KEY_LONG_1S_125M  : 1 s long-press window at 125 MHz, in clock cycles
//   key_cnt_w(n)      : bit width of a counter that must hold values 0..n
// -----------------------------------------------------------------------------
package key_pkg;

  localparam int KEY_DEB_40MS_125M = 5000000;
  localparam int KEY_LONG_1S_125M  = 125000000;

  function automatic int key_cnt_w(input longint n);
    return $clog2(n + 1);
  endfunction

endpackage : key_pkg

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One push-button channel: 2-flop synchroniser, polarity normalisation,
// stability filter, registered press/release pulses and (optionally) a
// long-press pulse.
//
// Optional feature: define KEY_LONG_PRESS_EN to build the hold counter and
// drive key_long; otherwise key_long is tied to 0.
//
// Ports
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   kin         : raw asynchronous key pin
//   key_state   : debounced level, 1 = pressed
//   key_press   : one-cycle pulse when a press is accepted
//   key_release : one-cycle pulse when a release is accepted
//   key_long    : one-cycle pulse LONG_CYCLES cycles after key_press
// -----------------------------------------------------------------------------
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEB_40MS_125M,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int LONG_CYCLES     = KEY_LONG_1S_125M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kin,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("key_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("key_debounce_ch: LONG_CYCLES must be >= 1");
  end

  localparam int               CNT_W    = key_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Pin level that means "not pressed" for this polarity.
  localparam logic             REL_LVL  = ACTIVE_LOW;

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_state;
  logic             r_press;
  logic             r_release;

  logic w_pressed_raw;
  logic w_toggle;

  assign w_pressed_raw = ACTIVE_LOW ? ~r_sync2 : r_sync2;
  // The filtered level flips on this cycle.
  assign w_toggle      = (w_pressed_raw != r_state) && (r_cnt == DEB_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the synchroniser stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchroniser resets to the released pin level so that reset release
      // with the key up never looks like a press.
      r_sync1   <= REL_LVL;
      r_sync2   <= REL_LVL;
      r_cnt     <= '0;
      r_state   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= kin;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (w_pressed_raw == r_state) begin
        // Any sample agreeing with the accepted level restarts the window.
        r_cnt <= '0;
      end else if (w_toggle) begin
        r_state   <= w_pressed_raw;
        r_cnt     <= '0;
        r_press   <= w_pressed_raw;
        r_release <= ~w_pressed_raw;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign key_state   = r_state;
  assign key_press   = r_press;
  assign key_release = r_release;

`ifdef KEY_LONG_PRESS_EN
  localparam int                HOLD_W    = key_cnt_w(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] r_hold;
  logic              r_long;

  // Hold counter is zero during the key_press cycle and saturates at
  // LONG_CYCLES, so the HOLD_LAST match (and hence key_long) happens once
  // per accepted press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_state || w_toggle) begin
        r_hold <= '0;
      end else begin
        if (r_hold != HOLD_MAX) begin
          r_hold <= r_hold + HOLD_W'(1);
        end
        if (r_hold == HOLD_LAST) begin
          r_long <= 1'b1;
        end
      end
    end
  end

  assign key_long = r_long;
`else
  assign key_long = 1'b0;
`endif

endmodule : key_debounce_ch

// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
// NUM_KEYS independent push-button conditioners; each bit of kin gets its own
// key_debounce_ch with no shared state.
//
// Optional feature: define KEY_LONG_PRESS_EN to enable the long-press pulse;
// without it key_long is constant 0.
//
// Ports
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   kin         : [NUM_KEYS] raw asynchronous key pins
//   key_state   : [NUM_KEYS] debounced levels, 1 = pressed
//   key_press   : [NUM_KEYS] one-cycle accepted-press pulses
//   key_release : [NUM_KEYS] one-cycle accepted-release pulses
//   key_long    : [NUM_KEYS] one-cycle long-press pulses
// -----------------------------------------------------------------------------
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = KEY_DEB_40MS_125M,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int LONG_CYCLES     = KEY_LONG_1S_125M
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] kin,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .kin        (kin[g]),
      .key_state  (key_state[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_long   (key_long[g])
    );
  end

endmodule : key_debounce_multi

// File: tb/tb_key_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_multi
// Directed bench for key_debounce_multi with NUM_KEYS=4, DEBOUNCE_CYCLES=8,
// LONG_CYCLES=20, ACTIVE_LOW=1. Inputs change and outputs are sampled on the
// falling clock edge; a clean pin edge shows on key_state at the 10th rising
// edge. Expected key_long activity depends on KEY_LONG_PRESS_EN.
// -----------------------------------------------------------------------------
module tb_key_debounce_multi;

  localparam int NK = 4;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [NK-1:0] LONG_EXP = 4'b0001;
`else
  localparam logic [NK-1:0] LONG_EXP = 4'b0000;
`endif

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] kin;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;

  int n_cmp = 0;
  int n_err = 0;

  key_debounce_multi #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW     (1'b1),
    .LONG_CYCLES    (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kin        (kin),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NK-1:0] obs,
                       input logic [NK-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance n falling edges, OR-ing every output seen along the way.
  task automatic idle(input int n, output logic [NK-1:0] as,
                      output logic [NK-1:0] ap, output logic [NK-1:0] ar,
                      output logic [NK-1:0] al);
    as = '0; ap = '0; ar = '0; al = '0;
    repeat (n) begin
      @(negedge clk);
      as |= key_state;
      ap |= key_press;
      ar |= key_release;
      al |= key_long;
    end
  endtask

  initial begin
    logic [NK-1:0] as, ap, ar, al;
    logic          bounce [5];
    bounce = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset with all keys released.
    kin   = 4'hF;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", key_state, 4'b0000);
    check("rst_pulses", key_press | key_release | key_long, 4'b0000);
    rst_n = 1'b1;
    idle(50, as, ap, ar, al);
    check("idle_state", as, 4'b0000);
    check("idle_press", ap, 4'b0000);
    check("idle_release", ar, 4'b0000);
    check("idle_long", al, 4'b0000);

    // Clean press / release on key 0.
    kin[0] = 1'b0;
    idle(9, as, ap, ar, al);
    check("k0_early_state", as, 4'b0000);
    check("k0_early_press", ap, 4'b0000);
    @(negedge clk);
    check("k0_press", key_press, 4'b0001);
    check("k0_state_on", key_state, 4'b0001);
    check("k0_no_rel", key_release, 4'b0000);
    @(negedge clk);
    check("k0_press_one_cycle", key_press, 4'b0000);
    kin[0] = 1'b1;
    idle(9, as, ap, ar, al);
    check("k0_early_release", ar, 4'b0000);
    check("k0_state_held", key_state, 4'b0001);
    @(negedge clk);
    check("k0_release", key_release, 4'b0001);
    check("k0_state_off", key_state, 4'b0000);
    @(negedge clk);
    check("k0_release_one_cycle", key_release, 4'b0000);

    // Key 1: 7-cycle pulse is rejected.
    kin[1] = 1'b0;
    repeat (7) @(negedge clk);
    kin[1] = 1'b1;
    idle(20, as, ap, ar, al);
    check("k1_short_state", as, 4'b0000);
    check("k1_short_press", ap, 4'b0000);
    check("k1_short_release", ar, 4'b0000);

    // Key 1: bounce then steady low gives a single press.
    for (int i = 0; i < 5; i++) begin
      kin[1] = bounce[i];
      @(negedge clk);
    end
    kin[1] = 1'b0;
    idle(9, as, ap, ar, al);
    check("k1_bounce_early", ap | as, 4'b0000);
    @(negedge clk);
    check("k1_bounce_press", key_press, 4'b0010);
    check("k1_bounce_state", key_state, 4'b0010);
    kin[1] = 1'b1;
    idle(12, as, ap, ar, al);
    check("k1_release_seen", ar, 4'b0010);
    check("k1_no_extra_press", ap, 4'b0000);
    check("k1_state_off", key_state, 4'b0000);

    // Keys 2 and 3 pressed together.
    kin[3:2] = 2'b00;
    idle(9, as, ap, ar, al);
    check("k23_early", ap, 4'b0000);
    @(negedge clk);
    check("k23_press", key_press, 4'b1100);
    check("k23_state", key_state, 4'b1100);
    kin[3:2] = 2'b11;
    idle(12, as, ap, ar, al);
    check("k23_release", ar, 4'b1100);
    check("k23_no_long", al, 4'b0000);
    check("k23_state_off", key_state, 4'b0000);

    // Reset in the middle of a count on key 0.
    kin[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_state", key_state | key_press, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    idle(9, as, ap, ar, al);
    check("midrst_early", ap | as, 4'b0000);
    @(negedge clk);
    check("midrst_press", key_press, 4'b0001);

    // Long hold on key 0.
    idle(19, as, ap, ar, al);
    check("long_early", al, 4'b0000);
    @(negedge clk);
    check("long_pulse", key_long, LONG_EXP);
    idle(100, as, ap, ar, al);
    check("long_no_repeat", al, 4'b0000);
    check("long_still_pressed", key_state, 4'b0001);
    kin[0] = 1'b1;
    idle(12, as, ap, ar, al);
    check("long_release", ar, 4'b0001);

    // Short hold on key 0: debounced release 14 cycles after the press.
    kin[0] = 1'b0;
    idle(9, as, ap, ar, al);
    @(negedge clk);
    check("short_press", key_press, 4'b0001);
    repeat (4) @(negedge clk);
    kin[0] = 1'b1;
    idle(40, as, ap, ar, al);
    check("short_no_long", al, 4'b0000);
    check("short_release", ar, 4'b0001);
    check("short_state_off", key_state, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_key_debounce_multi
